mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, memory wait states per load/store (0..15).
REQ-002 SHALL have parameter DEPTH, default 64, data memory size in 32-bit words (power of two).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port aluResultMEM  input  32  byte address or ALU result.
REQ-006 SHALL have port regReadData2MEM  input  32  store data.
REQ-007 SHALL have port registerMEM  input  5  destination register.
REQ-008 SHALL have ports memReadMEM, memWriteMEM, memtoRegMEM, regWriteMEM  input  1 each  control bits from the upstream pipeline register.
REQ-009 SHALL have port stallMEM  output  1  upstream must hold all MEM-side inputs and earlier stages while high.
REQ-010 SHALL have ports readDataWB, aluResultWB  output  32  registered load data / ALU result.
REQ-011 SHALL have ports registerWB (5), memtoRegWB (1), regWriteWB (1)  output  registered writeback controls.
REQ-012 SHALL have port alignErrWB  output  1  registered misaligned-access flag.

Function
REQ-013 Memory op = memReadMEM | memWriteMEM; word index = aluResultMEM[log2(DEPTH)+1:2]; upper bits ignored (wrap modulo DEPTH).
REQ-014 FSM states IDLE and WAIT, 4-bit counter cnt.
REQ-015 IDLE, memory op, WAIT_CYCLES>0: stallMEM=1 combinationally; next WAIT, cnt=WAIT_CYCLES-1.
REQ-016 WAIT: stallMEM=(cnt!=0); cnt!=0 -> cnt decrements; cnt==0 -> access completes this cycle, next IDLE.
REQ-017 Op presented in cycle T: stallMEM high T..T+WAIT_CYCLES-1, low at T+WAIT_CYCLES; completion edge is end of T+WAIT_CYCLES.
REQ-018 WAIT_CYCLES=0 or non-memory op: no stall; completes in the presenting cycle; FSM stays IDLE.
REQ-019 On completion edge: store writes regReadData2MEM exactly once; MEM/WB outputs capture readDataWB=mem[index] (pre-write contents), aluResultWB, registerWB, memtoRegWB, regWriteWB from inputs.
REQ-020 During stall cycles the MEM/WB register loads a bubble: regWriteWB=0, memtoRegWB=0, other data outputs zero.
REQ-021 readDataWB=0 when the completing op is not a read.
REQ-022 memReadMEM and memWriteMEM both high: handled as store; readDataWB returns pre-write word.
REQ-023 Latency MEM->WB one edge after completion; throughput one non-memory op per cycle.

Reset
REQ-024 rst_n low asynchronously forces IDLE, cnt=0, all WB outputs and alignErrWB to 0; stallMEM=0 while rst_n low.
REQ-025 Reset during WAIT aborts the access; no memory write committed.
REQ-026 Memory array contents are not cleared by reset.

Configuration
REQ-027 Macro MEM_STAGE_ALIGN_CHECK_EN defined: memory op with aluResultMEM[1:0]!=0 -> no stall, no write, bubble into WB, alignErrWB=1 for exactly the following cycle.
REQ-028 Macro undefined: alignErrWB tied 0, aluResultMEM[1:0] ignored, misaligned ops execute normally.

Verification
REQ-029 WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 -> stallMEM high 2 cycles, mem[4]=0xDEADBEEF after third edge, regWriteWB=0.
REQ-030 Then load 0x10, registerMEM=5 -> stall 2 cycles, then readDataWB=0xDEADBEEF, registerWB=5, memtoRegWB=1, regWriteWB=1.
REQ-031 Back-to-back ALU ops (regWrite, results 1,2,3) -> no stall, aluResultWB 1,2,3 on consecutive edges.
REQ-032 Store 0x12345678 to 0x20, rst_n low in WAIT -> stall drops immediately, WB outputs 0, later load 0x20 returns prior value.
REQ-033 With MEM_STAGE_ALIGN_CHECK_EN, load 0x13 -> no stall, alignErrWB=1 one cycle, regWriteWB=0; without macro, same op reads mem[4].
REQ-034 WAIT_CYCLES=0, store then load address 0xFC (DEPTH=64) -> no stall, load returns stored word; address 0x1FC aliases same word.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a wait-stated word memory and the MEM/WB register.
// Define MEM_STAGE_ALIGN_CHECK_EN to trap misaligned loads/stores instead of executing them.
module mem_stage #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aluResultMEM,
  input  logic [31:0] regReadData2MEM,
  input  logic [4:0]  registerMEM,
  input  logic        memReadMEM,
  input  logic        memWriteMEM,
  input  logic        memtoRegMEM,
  input  logic        regWriteMEM,
  output logic        stallMEM,
  output logic [31:0] readDataWB,
  output logic [31:0] aluResultWB,
  output logic [4:0]  registerWB,
  output logic        memtoRegWB,
  output logic        regWriteWB,
  output logic        alignErrWB
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          mem_op, misaligned, stall, complete;
  logic [AW-1:0] idx;
  logic [31:0]   read_word;
  logic [31:0]   mem [DEPTH];
  logic          unused_addr;

  assign mem_op      = memReadMEM | memWriteMEM;
  assign idx         = aluResultMEM[AW+1:2];
  assign read_word   = mem[idx];
  assign unused_addr = ^{aluResultMEM[31:AW+2], aluResultMEM[1:0]};

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misaligned = mem_op && (aluResultMEM[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A trapped misaligned op falls through IDLE as "complete" but is masked below.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    complete   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_op && !misaligned && (WAIT_CYCLES != 0)) begin
          stall      = 1'b1;
          state_next = S_WAIT;
          cnt_next   = CNT_INIT;
        end else begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          stall    = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign stallMEM = stall & rst_n;

  always_ff @(posedge clk) begin
    if (rst_n && complete && memWriteMEM && !misaligned)
      mem[idx] <= regReadData2MEM;
  end

  // Anything other than a clean completion loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readDataWB  <= '0;
      aluResultWB <= '0;
      registerWB  <= '0;
      memtoRegWB  <= 1'b0;
      regWriteWB  <= 1'b0;
    end else if (complete && !misaligned) begin
      readDataWB  <= memReadMEM ? read_word : 32'd0;
      aluResultWB <= aluResultMEM;
      registerWB  <= registerMEM;
      memtoRegWB  <= memtoRegMEM;
      regWriteWB  <= regWriteMEM;
    end else begin
      readDataWB  <= '0;
      aluResultWB <= '0;
      registerWB  <= '0;
      memtoRegWB  <= 1'b0;
      regWriteWB  <= 1'b0;
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alignErrWB <= 1'b0;
    else        alignErrWB <= misaligned;
  end
`else
  assign alignErrWB = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against an array-based memory model.
// A second instance with WAIT_CYCLES=0 covers the zero-wait and address-aliasing cases.
module tb_mem_stage;

  localparam int WAITS = 2;
  localparam int DEPTH = 64;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] aluResultMEM, regReadData2MEM, readDataWB, aluResultWB;
  logic [4:0]  registerMEM, registerWB;
  logic        memReadMEM, memWriteMEM, memtoRegMEM, regWriteMEM;
  logic        stallMEM, memtoRegWB, regWriteWB, alignErrWB;

  logic [31:0] zAlu, zWdata, zReadWB, zAluWB;
  logic [4:0]  zReg, zRegWB;
  logic        zRd, zWr, zM2r, zRw, zStall, zM2rWB, zRwWB, zAlignWB;

  mem_stage #(.WAIT_CYCLES(WAITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluResultMEM(aluResultMEM), .regReadData2MEM(regReadData2MEM), .registerMEM(registerMEM),
    .memReadMEM(memReadMEM), .memWriteMEM(memWriteMEM), .memtoRegMEM(memtoRegMEM),
    .regWriteMEM(regWriteMEM), .stallMEM(stallMEM), .readDataWB(readDataWB),
    .aluResultWB(aluResultWB), .registerWB(registerWB), .memtoRegWB(memtoRegWB),
    .regWriteWB(regWriteWB), .alignErrWB(alignErrWB)
  );

  mem_stage #(.WAIT_CYCLES(0), .DEPTH(DEPTH)) dutZero (
    .clk(clk), .rst_n(rst_n),
    .aluResultMEM(zAlu), .regReadData2MEM(zWdata), .registerMEM(zReg),
    .memReadMEM(zRd), .memWriteMEM(zWr), .memtoRegMEM(zM2r), .regWriteMEM(zRw),
    .stallMEM(zStall), .readDataWB(zReadWB), .aluResultWB(zAluWB), .registerWB(zRegWB),
    .memtoRegWB(zM2rWB), .regWriteWB(zRwWB), .alignErrWB(zAlignWB)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] modelMem [DEPTH];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic driveNop();
    aluResultMEM = '0; regReadData2MEM = '0; registerMEM = '0;
    memReadMEM = 0; memWriteMEM = 0; memtoRegMEM = 0; regWriteMEM = 0;
  endtask

  // One full transaction on the main instance, checked against the memory model.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rg, input logic rd, input logic wr,
                               input logic m2r, input logic rw);
    logic        isMem, mis;
    int          expStalls, idx, stalls;
    logic [31:0] expRead;
    isMem     = rd | wr;
    mis       = ALIGN && isMem && (addr[1:0] != 2'b00);
    expStalls = (isMem && !mis) ? WAITS : 0;
    idx       = int'(addr >> 2) % DEPTH;
    expRead   = (rd && !mis) ? modelMem[idx] : 32'd0;
    stalls    = 0;
    @(negedge clk);
    aluResultMEM = addr; regReadData2MEM = wdata; registerMEM = rg;
    memReadMEM = rd; memWriteMEM = wr; memtoRegMEM = m2r; regWriteMEM = rw;
    #1;
    while (stallMEM === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      checkOutput("bubbleRegWrite", {31'd0, regWriteWB}, 32'd0);
    end
    checkOutput("stallCycles", stalls, expStalls);
    @(posedge clk); #1;
    checkOutput("readDataWB", readDataWB, expRead);
    checkOutput("aluResultWB", aluResultWB, mis ? 32'd0 : addr);
    checkOutput("registerWB", {27'd0, registerWB}, mis ? 32'd0 : {27'd0, rg});
    checkOutput("memtoRegWB", {31'd0, memtoRegWB}, {31'd0, m2r & ~mis});
    checkOutput("regWriteWB", {31'd0, regWriteWB}, {31'd0, rw & ~mis});
    checkOutput("alignErrWB", {31'd0, alignErrWB}, {31'd0, mis});
    if (wr && !mis) modelMem[idx] = wdata;
  endtask

  task automatic zStep(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                       input logic wr, input logic [31:0] expRead);
    @(negedge clk);
    zAlu = addr; zWdata = wdata; zReg = 5'd9; zRd = rd; zWr = wr; zM2r = rd; zRw = rd;
    #1;
    checkOutput("zeroWaitStall", {31'd0, zStall}, 32'd0);
    @(posedge clk); #1;
    checkOutput("zeroWaitRead", zReadWB, expRead);
    checkOutput("zeroWaitRegWrite", {31'd0, zRwWB}, {31'd0, rd});
  endtask

  initial begin
    logic [31:0] addr;
    int op;
    driveNop();
    memReadMEM = 1;
    zAlu = '0; zWdata = '0; zReg = '0; zRd = 0; zWr = 0; zM2r = 0; zRw = 0;
    #12;
    checkOutput("resetStall", {31'd0, stallMEM}, 32'd0);
    checkOutput("resetReadData", readDataWB, 32'd0);
    checkOutput("resetAluResult", aluResultWB, 32'd0);
    checkOutput("resetRegWrite", {31'd0, regWriteWB}, 32'd0);
    checkOutput("resetAlignErr", {31'd0, alignErrWB}, 32'd0);
    @(negedge clk);
    driveNop();
    rst_n = 1;

    // Fill every word so later loads never see uninitialised storage; upper bits exercise wrap.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'(i * 4 + $urandom_range(0, 3) * DEPTH * 4), $urandom, 5'd0, 0, 1, 0, 0);

    applyStimulus(32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0);
    applyStimulus(32'h10, 32'h0, 5'd5, 1, 0, 1, 1);
    checkOutput("directedLoad", readDataWB, 32'hDEADBEEF);
    for (int i = 1; i <= 3; i++) applyStimulus(32'(i), 32'h0, 5'd3, 0, 0, 0, 1);
    applyStimulus(32'h13, 32'h0, 5'd6, 1, 0, 1, 1);
    applyStimulus(32'h40, 32'hA5A5A5A5, 5'd7, 1, 1, 1, 1);

    // Reset while a store is waiting must abort it without touching memory.
    @(negedge clk);
    aluResultMEM = 32'h20; regReadData2MEM = 32'h12345678; memWriteMEM = 1;
    @(posedge clk); #2;
    checkOutput("stallBeforeReset", {31'd0, stallMEM}, 32'd1);
    rst_n = 0;
    #1;
    checkOutput("stallInReset", {31'd0, stallMEM}, 32'd0);
    checkOutput("wbInReset", {aluResultWB[30:0], regWriteWB}, 32'd0);
    @(negedge clk);
    driveNop();
    rst_n = 1;
    applyStimulus(32'h20, 32'h0, 5'd8, 1, 0, 1, 1);

    for (int n = 0; n < 150; n++) begin
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      op = $urandom_range(0, 3);
      applyStimulus(addr, $urandom, 5'($urandom), op[0], op[1], 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    driveNop();
    zStep(32'hFC, 32'hCAFEF00D, 0, 1, 32'd0);
    zStep(32'hFC, 32'h0, 1, 0, 32'hCAFEF00D);
    zStep(32'h1FC, 32'h0, 1, 0, 32'hCAFEF00D);
    zStep(32'h1FC, 32'h0BADCAFE, 1, 1, 32'hCAFEF00D);
    zStep(32'hFC, 32'h0, 1, 0, 32'h0BADCAFE);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
